// File: rtl/pgm_ddram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pgm_ddram_arbiter
// Purpose  : Shares the 64-bit DDRAM port between the ROM loader (writes),
//            the 68000 CPU (reads) and the video engine (reads). Only one
//            transaction is in flight at a time. Busy back-pressure is honoured,
//            and read data is captured into per-requester registers.
//
//            Grant priority in IDLE:
//              loader > starved video > CPU > video
//
// Ports    : fixed_50m_clk, reset     - sole clock, synchronous active-high reset
//            ldr_req/addr/din/be/ack  - loader write channel
//            cpu_req/addr/ack/data    - CPU read channel
//            vid_req/addr/ack/data    - video read channel
//            ddram_rd/we/addr/din/be  - command side toward DDRAM
//            ddram_dout/busy/dout_ready - DDRAM responses
// Revision : 1.0 - initial release
// ============================================================================
module pgm_ddram_arbiter #(
  parameter int VID_MAX_WAIT = 16
) (
  input  logic        fixed_50m_clk,
  input  logic        reset,
  input  logic        ldr_req,
  input  logic [28:0] ldr_addr,
  input  logic [63:0] ldr_din,
  input  logic [7:0]  ldr_be,
  output logic        ldr_ack,
  input  logic        cpu_req,
  input  logic [28:0] cpu_addr,
  output logic        cpu_ack,
  output logic [63:0] cpu_data,
  input  logic        vid_req,
  input  logic [28:0] vid_addr,
  output logic        vid_ack,
  output logic [63:0] vid_data,
  output logic        ddram_rd,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_busy,
  input  logic        ddram_dout_ready
);

  localparam logic [1:0] C_ST_IDLE    = 2'd0;
  localparam logic [1:0] C_ST_ISSUE   = 2'd1;
  localparam logic [1:0] C_ST_WAIT_RD = 2'd2;
  localparam logic [1:0] C_ST_DONE    = 2'd3;

  // Code 0 means "no owner yet" and is the reset value.
  localparam logic [1:0] C_OWN_LDR = 2'd1;
  localparam logic [1:0] C_OWN_CPU = 2'd2;
  localparam logic [1:0] C_OWN_VID = 2'd3;

  localparam logic [7:0] C_VID_MAX = 8'(VID_MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [28:0] addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic [7:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        we_q, we_d;
  logic        ldr_ack_q, ldr_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        vid_ack_q, vid_ack_d;
  logic [63:0] cpu_data_q, cpu_data_d;
  logic [63:0] vid_data_q, vid_data_d;

  logic        w_vid_starved;
  logic        w_vid_grant;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    din_d      = din_q;
    be_d       = be_q;
    rd_d       = rd_q;
    we_d       = we_q;
    ldr_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    vid_ack_d  = 1'b0;
    cpu_data_d = cpu_data_q;
    vid_data_d = vid_data_q;

    w_vid_starved = (cnt_q >= C_VID_MAX);
    w_vid_grant   = 1'b0;

    case (state_q)
      C_ST_IDLE: begin
        if (ldr_req) begin
          owner_d = C_OWN_LDR;
          addr_d  = ldr_addr;
          din_d   = ldr_din;
          be_d    = ldr_be;
          we_d    = 1'b1;
          state_d = C_ST_ISSUE;
        end else if (vid_req && (w_vid_starved || !cpu_req)) begin
          // Video takes the slot when it is starved, or when the CPU is idle.
          w_vid_grant = 1'b1;
          owner_d     = C_OWN_VID;
          addr_d      = vid_addr;
          rd_d        = 1'b1;
          state_d     = C_ST_ISSUE;
        end else if (cpu_req) begin
          owner_d = C_OWN_CPU;
          addr_d  = cpu_addr;
          rd_d    = 1'b1;
          state_d = C_ST_ISSUE;
        end
      end

      C_ST_ISSUE: begin
        // The command stays on the bus until the first cycle with busy low.
        if (!ddram_busy) begin
          rd_d = 1'b0;
          we_d = 1'b0;
          if (owner_q == C_OWN_LDR) begin
            ldr_ack_d = 1'b1;
            state_d   = C_ST_DONE;
          end else begin
            state_d = C_ST_WAIT_RD;
          end
        end
      end

      C_ST_WAIT_RD: begin
        if (ddram_dout_ready) begin
          if (owner_q == C_OWN_CPU) begin
            cpu_data_d = ddram_dout;
            cpu_ack_d  = 1'b1;
          end else begin
            vid_data_d = ddram_dout;
            vid_ack_d  = 1'b1;
          end
          state_d = C_ST_DONE;
        end
      end

      C_ST_DONE: begin
        state_d = C_ST_IDLE;
      end

      default: begin
        state_d = C_ST_IDLE;
      end
    endcase

    // Starvation counter: video waiting while someone else owns the port.
    cnt_d = cnt_q;
    if (w_vid_grant || !vid_req) begin
      cnt_d = 8'd0;
    end else if ((owner_q != C_OWN_VID) && (cnt_q < C_VID_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      state_q    <= C_ST_IDLE;
      owner_q    <= 2'd0;
      cnt_q      <= 8'd0;
      addr_q     <= 29'd0;
      din_q      <= 64'd0;
      be_q       <= 8'd0;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      ldr_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_data_q <= 64'd0;
      vid_data_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      ldr_ack_q  <= ldr_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_ack_q  <= vid_ack_d;
      cpu_data_q <= cpu_data_d;
      vid_data_q <= vid_data_d;
    end
  end

  assign ddram_rd   = rd_q;
  assign ddram_we   = we_q;
  assign ddram_addr = addr_q;
  assign ddram_din  = din_q;
  assign ddram_be   = be_q;
  assign ldr_ack    = ldr_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign vid_ack    = vid_ack_q;
  assign cpu_data   = cpu_data_q;
  assign vid_data   = vid_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pgm_ddram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pgm_ddram_arbiter
// Purpose  : Scoreboard bench for pgm_ddram_arbiter.
//
//            A transaction-level reference model predicts the following:
//              - which requester wins each free slot;
//              - the cycle its command appears;
//              - the cycle and data of its ack.
//            Predictions are queued, and a monitor pops them as the DUT
//            presents commands and acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgm_ddram_arbiter;

  localparam int VMAX = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ldr_req = 1'b0, cpu_req = 1'b0, vid_req = 1'b0;
  logic [28:0] ldr_addr = '0, cpu_addr = '0, vid_addr = '0;
  logic [63:0] ldr_din = '0;
  logic [7:0]  ldr_be = '0;
  logic        ldr_ack, cpu_ack, vid_ack;
  logic [63:0] cpu_data, vid_data;
  logic        ddram_rd, ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [63:0] ddram_dout = '0;
  logic        ddram_busy = 1'b0, ddram_dout_ready = 1'b0;

  always #5 clk = ~clk;

  pgm_ddram_arbiter #(.VID_MAX_WAIT(VMAX)) dut (
    .fixed_50m_clk(clk), .reset(reset),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_be(ldr_be), .ldr_ack(ldr_ack),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
    .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready)
  );

  // who: 1 = loader, 2 = CPU, 3 = video
  typedef struct { int who; logic [28:0] addr; logic [63:0] din; logic [7:0] be; int cyc; } cmd_t;
  typedef struct { int who; logic [63:0] data; int cyc; } ack_t;
  cmd_t cmdq[$];
  ack_t ackq[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int vid_ack_cnt = 0;

  // Reference model: transaction phase (0 free, 1 command out, 2 awaiting data, 3 acking)
  int ph = 0, m_own = 0, m_wait = 0, m_ready_at = -1, m_acked = 0;
  logic [28:0] addr_cur = '0, addr_nxt = '0;
  logic [63:0] din_cur = '0, din_nxt = '0, cpu_cur = '0, cpu_nxt = '0, vid_cur = '0, vid_nxt = '0;
  logic [7:0]  be_cur = '0, be_nxt = '0;

  // Stimulus knobs
  int  mode_ldr = 0, mode_cpu = 0, mode_vid = 0;   // 0 manual, 1 continuous, 2 random
  bit  kick_ldr = 0, kick_cpu = 0, kick_vid = 0, kick_reset = 0, hold_reset = 1;
  bit  rand_busy = 0, rand_stray = 0, stray_now = 0;
  int  busy_left = 0, fixed_lat = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive();
    reset = hold_reset || kick_reset;
    kick_reset = 1'b0;
    if (reset || m_acked == 1) ldr_req = 1'b0;
    else if (!ldr_req && (kick_ldr || mode_ldr == 1 || (mode_ldr == 2 && $urandom_range(0, 15) == 0))) begin
      if (!kick_ldr) begin
        ldr_addr = 29'($urandom); ldr_din = {$urandom, $urandom}; ldr_be = 8'($urandom);
      end
      ldr_req = 1'b1;
    end
    if (reset || m_acked == 2) cpu_req = 1'b0;
    else if (!cpu_req && (kick_cpu || mode_cpu == 1 || (mode_cpu == 2 && $urandom_range(0, 2) == 0))) begin
      if (!kick_cpu) cpu_addr = 29'($urandom);
      cpu_req = 1'b1;
    end
    if (reset || m_acked == 3) vid_req = 1'b0;
    else if (!vid_req && (kick_vid || mode_vid == 1 || (mode_vid == 2 && $urandom_range(0, 2) == 0))) begin
      if (!kick_vid) vid_addr = 29'($urandom);
      vid_req = 1'b1;
    end
    kick_ldr = 1'b0; kick_cpu = 1'b0; kick_vid = 1'b0;

    if (ph == 1 && busy_left > 0) begin
      ddram_busy = 1'b1;
      busy_left--;
    end else begin
      ddram_busy = rand_busy && ($urandom_range(0, 2) == 0);
    end

    ddram_dout_ready = 1'b0;
    if (cyc == m_ready_at || stray_now || (rand_stray && ph != 2 && $urandom_range(0, 9) == 0)) begin
      ddram_dout_ready = 1'b1;
      ddram_dout = {$urandom, $urandom};
    end
    stray_now = 1'b0;
  endtask

  // Predicts what the DUT shows in the next cycle from the inputs of this cycle.
  task automatic model_step();
    int   w;
    cmd_t c;
    ack_t a;
    addr_cur = addr_nxt; din_cur = din_nxt; be_cur = be_nxt;
    cpu_cur = cpu_nxt; vid_cur = vid_nxt;
    m_acked = 0;
    if (reset) begin
      ph = 0; m_own = 0; m_wait = 0;
      addr_nxt = '0; din_nxt = '0; be_nxt = '0; cpu_nxt = '0; vid_nxt = '0;
      cmdq.delete(); ackq.delete();
      return;
    end
    w = 0;
    if (ph == 0) begin
      if (ldr_req) w = 1;
      else if (vid_req && m_wait >= VMAX) w = 3;
      else if (cpu_req) w = 2;
      else if (vid_req) w = 3;
    end
    if (w == 3 || !vid_req) m_wait = 0;
    else if (m_own != 3 && m_wait < VMAX) m_wait++;
    case (ph)
      0: if (w != 0) begin
        m_own = w;
        c.who = w; c.cyc = cyc + 1;
        if (w == 1) begin addr_nxt = ldr_addr; din_nxt = ldr_din; be_nxt = ldr_be; end
        else addr_nxt = (w == 2) ? cpu_addr : vid_addr;
        c.addr = addr_nxt; c.din = din_nxt; c.be = be_nxt;
        cmdq.push_back(c);
        ph = 1;
      end
      1: if (!ddram_busy) begin
        if (m_own == 1) begin
          a.who = 1; a.data = '0; a.cyc = cyc + 1; ackq.push_back(a); ph = 3;
        end else begin
          m_ready_at = cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6)));
          ph = 2;
        end
      end
      2: if (ddram_dout_ready) begin
        if (m_own == 2) cpu_nxt = ddram_dout; else vid_nxt = ddram_dout;
        a.who = m_own; a.data = ddram_dout; a.cyc = cyc + 1; ackq.push_back(a);
        ph = 3;
      end
      default: begin ph = 0; m_acked = m_own; end
    endcase
  endtask

  task automatic step_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic check_rst();
    chk("rst_rd", ddram_rd, 0); chk("rst_we", ddram_we, 0);
    chk("rst_acks", {ldr_ack, cpu_ack, vid_ack}, 0);
    chk("rst_cpu_data", cpu_data, 0); chk("rst_vid_data", vid_data, 0);
    chk("rst_addr", ddram_addr, 0); chk("rst_din", ddram_din, 0); chk("rst_be", ddram_be, 0);
  endtask

  // Monitor: compares DUT outputs against queued predictions.
  initial begin
    cmd_t held;
    ack_t a;
    bit   prev_cmd, prev_busy;
    prev_cmd = 0; prev_busy = 0;
    held.who = 0; held.addr = '0; held.din = '0; held.be = '0; held.cyc = 0;
    forever begin
      @(negedge clk);
      if (reset || cyc < 1) begin prev_cmd = 0; continue; end
      if (ddram_rd || ddram_we) begin
        if (prev_cmd && prev_busy) begin
          chk("cmd_hold_kind", {ddram_we, ddram_rd}, (held.who == 1) ? 2'b10 : 2'b01);
          chk("cmd_hold_addr", ddram_addr, held.addr);
          if (held.who == 1) begin
            chk("cmd_hold_din", ddram_din, held.din); chk("cmd_hold_be", ddram_be, held.be);
          end
        end else if (cmdq.size() == 0) begin
          chk("cmd_unexpected", {ddram_we, ddram_rd}, 0);
        end else begin
          held = cmdq.pop_front();
          chk("cmd_cycle", 64'(cyc), 64'(held.cyc));
          chk("cmd_kind", {ddram_we, ddram_rd}, (held.who == 1) ? 2'b10 : 2'b01);
          chk("cmd_addr", ddram_addr, held.addr);
          if (held.who == 1) begin
            chk("cmd_din", ddram_din, held.din); chk("cmd_be", ddram_be, held.be);
          end
        end
        prev_cmd = 1; prev_busy = ddram_busy;
      end else begin
        prev_cmd = 0;
      end
      if (ldr_ack || cpu_ack || vid_ack) begin
        if (vid_ack) vid_ack_cnt++;
        if (ackq.size() == 0) chk("ack_unexpected", {ldr_ack, cpu_ack, vid_ack}, 0);
        else begin
          a = ackq.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(a.cyc));
          chk("ack_who", {ldr_ack, cpu_ack, vid_ack}, (a.who == 1) ? 3'b100 : (a.who == 2) ? 3'b010 : 3'b001);
          if (a.who == 2) chk("ack_cpu_data", cpu_data, a.data);
          if (a.who == 3) chk("ack_vid_data", vid_data, a.data);
        end
      end
      chk("hold_cpu_data", cpu_data, cpu_cur);
      chk("hold_vid_data", vid_data, vid_cur);
      chk("hold_addr", ddram_addr, addr_cur);
      chk("hold_din", ddram_din, din_cur);
      chk("hold_be", ddram_be, be_cur);
    end
  end

  initial begin
    int v0;
    run(3);
    check_rst();
    hold_reset = 0;
    run(3);

    // Plain CPU read, L = 4: command one cycle after grant, ack at 2+L.
    cpu_addr = 29'h0000123; fixed_lat = 4; kick_cpu = 1;
    run(20);

    // Loader write held through three busy cycles.
    ldr_addr = 29'h1ABCDEF; ldr_din = 64'h0123_4567_89AB_CDEF; ldr_be = 8'h0C;
    busy_left = 3; kick_ldr = 1;
    run(20);

    // CPU and video both requesting continuously: video must still get slots.
    fixed_lat = 2; v0 = vid_ack_cnt;
    mode_cpu = 1; mode_vid = 1;
    run(200);
    mode_cpu = 0; mode_vid = 0;
    run(30);
    chk("starved_vid_granted", 64'(vid_ack_cnt > v0), 1);

    // All three in the same cycle: LDR, CPU, VID order.
    ldr_addr = 29'h0000010; ldr_din = 64'hFEED; ldr_be = 8'hFF;
    cpu_addr = 29'h0000020; vid_addr = 29'h0000030;
    kick_ldr = 1; kick_cpu = 1; kick_vid = 1;
    run(40);

    // Stray dout_ready while idle, then a video read.
    stray_now = 1;
    run(3);
    vid_addr = 29'h0ABCDE0; kick_vid = 1;
    run(20);

    // Reset while waiting for read data; the late strobe must be ignored.
    cpu_addr = 29'h0000555; fixed_lat = 8; kick_cpu = 1;
    run(3);
    kick_reset = 1;
    run(15);
    check_rst();
    fixed_lat = 3; cpu_addr = 29'h0000777; kick_cpu = 1;
    run(20);

    // Randomised traffic with busy and stray strobes.
    fixed_lat = 0; rand_busy = 1; rand_stray = 1;
    mode_ldr = 2; mode_cpu = 2; mode_vid = 2;
    run(3000);
    mode_ldr = 0; mode_cpu = 0; mode_vid = 0; rand_stray = 0;
    run(60);
    chk("cmdq_drained", 64'(cmdq.size()), 0);
    chk("ackq_drained", 64'(ackq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
